servo_pwm3: RTL

Three-channel servo PWM output stage. It consumes the 16-bit pulse-width words (in µs) produced by the motion sequencer and drives the three servo control pins. Each frame is a fixed 20 ms period with µs resolution. New widths are double-buffered and take effect only at a frame boundary, so a servo never sees a torn pulse. Out-of-range widths are clamped.

---
 rtl/servo_pkg.sv | 24 ++
 rtl/servo_pwm_ch.sv | 61 ++++++
 rtl/servo_pwm3.sv | 87 ++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared constants, types and the clamp helper used by the three-channel
// servo PWM output stage and its per-channel slice.
package servo_pkg;

  localparam int TICK_DIV   = 50;
  localparam int FRAME_US   = 20000;
  localparam int PW_MIN     = 500;
  localparam int PW_MAX     = 2500;
  localparam int PW_DEFAULT = 1500;

  typedef logic [15:0] pw_t;
  typedef logic [14:0] us_t;

  function automatic pw_t clamp_pw(
    input pw_t x,
    input pw_t lo,
    input pw_t hi
  );
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: pending/active width registers, clamp and pin compare.
// Ports: clk, rst_n, upd (capture), apply (boundary with pending),
//   pul_len (requested us), us_cnt (frame position), pin, clamp_evt.
module servo_pwm_ch
  import servo_pkg::*;
#(
  parameter int PW_MIN     = servo_pkg::PW_MIN,
  parameter int PW_MAX     = servo_pkg::PW_MAX,
  parameter int PW_DEFAULT = servo_pkg::PW_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic upd,
  input  logic apply,
  input  pw_t  pul_len,
  input  us_t  us_cnt,
  output logic pin,
  output logic clamp_evt
);

  localparam pw_t LO  = pw_t'(PW_MIN);
  localparam pw_t HI  = pw_t'(PW_MAX);
  localparam pw_t DEF = pw_t'(PW_DEFAULT);

  pw_t  pend_q, pend_d;
  pw_t  active_q, active_d;
  logic pin_q, pin_d;
  logic clamp_q, clamp_d;

  // Apply reads the old pend_q, so a capture on the
  // boundary cycle waits for the following frame.
  always_comb begin
    pend_d   = pend_q;
    active_d = active_q;
    clamp_d  = 1'b0;
    if (apply) active_d = pend_q;
    if (upd) begin
      pend_d  = clamp_pw(pul_len, LO, HI);
      clamp_d = (pul_len < LO) || (pul_len > HI);
    end
    pin_d = {1'b0, us_cnt} < active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= DEF;
      active_q <= DEF;
      pin_q    <= 1'b0;
      clamp_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      active_q <= active_d;
      pin_q    <= pin_d;
      clamp_q  <= clamp_d;
    end
  end

  assign pin       = pin_q;
  assign clamp_evt = clamp_q;

endmodule

// File: rtl/servo_pwm3.sv
// Three-channel servo PWM stage: shared us prescaler and frame counter,
// double-buffered widths applied at frame boundaries.
// Ports: CLK, rst_n, pul_len1..3, upd, pending, frame_start,
//   clamp_evt[2:0], CTL_PIN[2:0] (bit 0 = channel 1).
module servo_pwm3
  import servo_pkg::*;
#(
  parameter int TICK_DIV   = servo_pkg::TICK_DIV,
  parameter int FRAME_US   = servo_pkg::FRAME_US,
  parameter int PW_MIN     = servo_pkg::PW_MIN,
  parameter int PW_MAX     = servo_pkg::PW_MAX,
  parameter int PW_DEFAULT = servo_pkg::PW_DEFAULT
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [15:0] pul_len1,
  input  logic [15:0] pul_len2,
  input  logic [15:0] pul_len3,
  input  logic        upd,
  output logic        pending,
  output logic        frame_start,
  output logic [2:0]  clamp_evt,
  output logic [2:0]  CTL_PIN
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_q, tick_d;
  us_t           us_q, us_d;
  logic          pending_q, pending_d;
  logic          tick_wrap;
  logic          boundary;
  pw_t           len [3];

  always_comb begin
    tick_wrap = (tick_q == TW'(TICK_DIV - 1));
    tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
    us_d      = us_q;
    if (tick_wrap) begin
      us_d = (us_q == us_t'(FRAME_US - 1)) ? '0 : us_q + 1'b1;
    end
    boundary  = (tick_q == '0) && (us_q == '0);
    // A capture on the boundary cycle wins over the clear.
    pending_d = pending_q;
    if (boundary) pending_d = 1'b0;
    if (upd)      pending_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= '0;
      us_q      <= '0;
      pending_q <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      us_q      <= us_d;
      pending_q <= pending_d;
    end
  end

  // Counters sit at zero out of reset, so the first
  // running cycle is already a boundary.
  assign frame_start = boundary & rst_n;
  assign pending     = pending_q;

  assign len[0] = pul_len1;
  assign len[1] = pul_len2;
  assign len[2] = pul_len3;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    servo_pwm_ch #(
      .PW_MIN    (PW_MIN),
      .PW_MAX    (PW_MAX),
      .PW_DEFAULT(PW_DEFAULT)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (rst_n),
      .upd      (upd),
      .apply    (boundary & pending_q),
      .pul_len  (len[g]),
      .us_cnt   (us_q),
      .pin      (CTL_PIN[g]),
      .clamp_evt(clamp_evt[g])
    );
  end

endmodule
